// File: rtl/intra_pkg.sv
// Shared definitions for the 4x4 intra prediction scorers.
//   - Pixel/score geometry used by intra4_mode_select and sse4x4.
//   - VP8 4x4 intra mode identifiers.
//   - Mode-select FSM state encoding.
package intra_pkg;

  localparam int BIT_WIDTH   = 8;
  localparam int BLOCK_SIZE  = 4;
  localparam int NPIX        = BLOCK_SIZE * BLOCK_SIZE;
  localparam int MODE_WIDTH  = 4;
  // 2*BIT_WIDTH for one square plus log2(NPIX) for the 16-way sum.
  localparam int SCORE_WIDTH = 20;

  typedef logic [MODE_WIDTH-1:0] mode_t;

  localparam mode_t MODE_DC = 4'd0;
  localparam mode_t MODE_TM = 4'd1;
  localparam mode_t MODE_VE = 4'd2;
  localparam mode_t MODE_HE = 4'd3;
  localparam mode_t MODE_RD = 4'd4;
  localparam mode_t MODE_VR = 4'd5;
  localparam mode_t MODE_LD = 4'd6;
  localparam mode_t MODE_VL = 4'd7;
  localparam mode_t MODE_HD = 4'd8;
  localparam mode_t MODE_HU = 4'd9;

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,  // accepting prediction beats
    ST_DRAIN = 2'd1,  // last beat in flight through the scorer
    ST_HOLD  = 2'd2   // result presented, waiting for out_ready
  } state_e;

endpackage

// File: rtl/sse4x4.sv
// Sum of squared errors between a source block and a predicted block.
//   clk    : clock
//   src    : source block, pixel i at [BIT_WIDTH*i +: BIT_WIDTH]
//   pred   : predicted block, same packing
//   diff_q : per-pixel signed src-pred, (BIT_WIDTH+1) bits per lane,
//            one cycle after src/pred
//   sse_q  : sum of squared differences, two cycles after src/pred
// Pure datapath: no valid tracking, callers carry their own valid bits
// alongside the two register stages.
module sse4x4 #(
  parameter int BIT_WIDTH   = intra_pkg::BIT_WIDTH,
  parameter int NPIX        = intra_pkg::NPIX,
  parameter int SCORE_WIDTH = intra_pkg::SCORE_WIDTH
) (
  input  logic                           clk,
  input  logic [BIT_WIDTH*NPIX-1:0]      src,
  input  logic [BIT_WIDTH*NPIX-1:0]      pred,
  output logic [(BIT_WIDTH+1)*NPIX-1:0]  diff_q,
  output logic [SCORE_WIDTH-1:0]         sse_q
);

  localparam int DW = BIT_WIDTH + 1;   // signed difference width
  localparam int SW = 2 * BIT_WIDTH;   // square width

  logic [DW*NPIX-1:0] diff_d;
  logic [SW*NPIX-1:0] sq_d;
  logic [SW*NPIX-1:0] sq_q;
  logic [SCORE_WIDTH-1:0] sse_d;

  for (genvar i = 0; i < NPIX; i++) begin : g_lane
    logic signed [DW-1:0] d;
    logic signed [SW-1:0] dx;
    assign d  = $signed({1'b0, src[i*BIT_WIDTH +: BIT_WIDTH]})
              - $signed({1'b0, pred[i*BIT_WIDTH +: BIT_WIDTH]});
    // Sign-extend before multiplying so the product is computed at the
    // full square width; |d| <= 2^BIT_WIDTH-1 so the square always fits.
    assign dx = {{(SW-DW){d[DW-1]}}, d};
    assign diff_d[i*DW +: DW] = d;
    assign sq_d[i*SW +: SW]   = dx * dx;
  end

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    sse_d = '0;
    for (int i = 0; i < NPIX; i++) begin
      sse_d = sse_d + SCORE_WIDTH'(sq_q[i*SW +: SW]);
    end
  end

  // NOTE: pure datapath registers carry no reset; their contents only matter
  // when the caller's (reset) valid bits say so, and skipping the reset keeps
  // these wide registers cheap. Sequential state uses <= so every register
  // in a block samples pre-edge values.
  always_ff @(posedge clk) begin
    diff_q <= diff_d;
    sq_q   <= sq_d;
    sse_q  <= sse_d;
  end

endmodule

// File: rtl/intra4_mode_select.sv
// Picks the lowest-SSE 4x4 intra mode for one source block.
//   clk, rst              : clock, asynchronous active-high reset
//   in_valid/in_ready     : one predicted block (one mode) per beat
//   in_last               : beat carries the final mode of the block
//   in_mode, in_pred      : mode id and its prediction
//   in_src                : source block, sampled on the block's first beat
//   out_valid/out_ready   : result handshake
//   out_mode, out_score   : winning mode and its SSE
//   out_pred, out_resid   : winning prediction and signed src-pred residual
// Pipeline: stage 1 (diffs/squares) -> stage 2 (sse) -> best-mode update ->
// HOLD. Outputs are the best-mode registers themselves.
module intra4_mode_select #(
  parameter int BIT_WIDTH   = intra_pkg::BIT_WIDTH,
  parameter int BLOCK_SIZE  = intra_pkg::BLOCK_SIZE,
  parameter int MODE_WIDTH  = intra_pkg::MODE_WIDTH,
  parameter int SCORE_WIDTH = intra_pkg::SCORE_WIDTH
) (
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic                                              in_valid,
  output logic                                              in_ready,
  input  logic                                              in_last,
  input  logic [MODE_WIDTH-1:0]                             in_mode,
  input  logic [BIT_WIDTH*BLOCK_SIZE*BLOCK_SIZE-1:0]        in_src,
  input  logic [BIT_WIDTH*BLOCK_SIZE*BLOCK_SIZE-1:0]        in_pred,
  output logic                                              out_valid,
  input  logic                                              out_ready,
  output logic [MODE_WIDTH-1:0]                             out_mode,
  output logic [SCORE_WIDTH-1:0]                            out_score,
  output logic [BIT_WIDTH*BLOCK_SIZE*BLOCK_SIZE-1:0]        out_pred,
  output logic [(BIT_WIDTH+1)*BLOCK_SIZE*BLOCK_SIZE-1:0]    out_resid
);

  import intra_pkg::state_e;
  import intra_pkg::ST_ACCUM;
  import intra_pkg::ST_DRAIN;
  import intra_pkg::ST_HOLD;

  localparam int NPIX = BLOCK_SIZE * BLOCK_SIZE;
  localparam int PW   = BIT_WIDTH * NPIX;
  localparam int RW   = (BIT_WIDTH + 1) * NPIX;

  state_e state_q, state_d;
  logic   first_q, first_d;   // next accepted beat opens a new block
  logic   done_q,  done_d;    // last beat has left stage 2
  logic   accept;

  logic [PW-1:0] src_q, src_d;
  logic [PW-1:0] src_eff;

  // Sideband travelling with the scorer's two register stages.
  logic                  s1_valid_q, s2_valid_q;
  logic                  s1_last_q,  s2_last_q;
  logic                  s1_first_q, s2_first_q;
  logic [MODE_WIDTH-1:0] s1_mode_q,  s2_mode_q;
  logic [PW-1:0]         s1_pred_q,  s2_pred_q;
  logic [RW-1:0]         s1_diff,    s2_resid_q;
  logic [SCORE_WIDTH-1:0] s2_sse;

  logic                   take;
  logic [MODE_WIDTH-1:0]  best_mode_q,  best_mode_d;
  logic [SCORE_WIDTH-1:0] best_score_q, best_score_d;
  logic [PW-1:0]          best_pred_q,  best_pred_d;
  logic [RW-1:0]          best_resid_q, best_resid_d;

  // in_ready depends on the state register only, never on in_valid.
  assign accept = in_valid && (state_q == ST_ACCUM);

  // The first beat scores against the live source; later beats use the copy.
  assign src_eff = first_q ? in_src : src_q;
  assign src_d   = (accept && first_q) ? in_src : src_q;

  sse4x4 #(
    .BIT_WIDTH  (BIT_WIDTH),
    .NPIX       (NPIX),
    .SCORE_WIDTH(SCORE_WIDTH)
  ) u_sse (
    .clk   (clk),
    .src   (src_eff),
    .pred  (in_pred),
    .diff_q(s1_diff),
    .sse_q (s2_sse)
  );

  // Strict less-than: on equal scores the earlier mode keeps the slot.
  assign take = s2_valid_q && (s2_first_q || (s2_sse < best_score_q));

  always_comb begin
    best_mode_d  = best_mode_q;
    best_score_d = best_score_q;
    best_pred_d  = best_pred_q;
    best_resid_d = best_resid_q;
    if (take) begin
      best_mode_d  = s2_mode_q;
      best_score_d = s2_sse;
      best_pred_d  = s2_pred_q;
      best_resid_d = s2_resid_q;
    end
  end

  assign done_d = s2_valid_q && s2_last_q;

  always_comb begin
    state_d   = state_q;
    first_d   = first_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    if (accept) first_d = 1'b0;
    unique case (state_q)
      ST_ACCUM: begin
        in_ready = 1'b1;
        if (accept && in_last) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (done_q) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = ST_ACCUM;
          first_d = 1'b1;
        end
      end
      default: state_d = ST_ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_ACCUM;
      first_q      <= 1'b1;
      done_q       <= 1'b0;
      s1_valid_q   <= 1'b0;
      s2_valid_q   <= 1'b0;
      best_mode_q  <= '0;
      best_score_q <= '0;
      best_pred_q  <= '0;
      best_resid_q <= '0;
    end else begin
      state_q      <= state_d;
      first_q      <= first_d;
      done_q       <= done_d;
      s1_valid_q   <= accept;
      s2_valid_q   <= s1_valid_q;
      best_mode_q  <= best_mode_d;
      best_score_q <= best_score_d;
      best_pred_q  <= best_pred_d;
      best_resid_q <= best_resid_d;
    end
  end

  always_ff @(posedge clk) begin
    src_q      <= src_d;
    s1_last_q  <= in_last;
    s1_first_q <= first_q;
    s1_mode_q  <= in_mode;
    s1_pred_q  <= in_pred;
    s2_last_q  <= s1_last_q;
    s2_first_q <= s1_first_q;
    s2_mode_q  <= s1_mode_q;
    s2_pred_q  <= s1_pred_q;
    s2_resid_q <= s1_diff;
  end

  assign out_mode  = best_mode_q;
  assign out_score = best_score_q;
  assign out_pred  = best_pred_q;
  assign out_resid = best_resid_q;

endmodule

// File: tb/tb_intra4_mode_select.sv
// Self-checking bench for intra4_mode_select: directed cases with literal
// expectations, then randomized blocks scored by a plain-arithmetic model.
module tb_intra4_mode_select;
  import intra_pkg::*;

  localparam int PW = 128;
  localparam int RW = 144;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, in_last;
  logic [3:0]    in_mode;
  logic [PW-1:0] in_src, in_pred;
  logic          out_valid, out_ready;
  logic [3:0]    out_mode;
  logic [19:0]   out_score;
  logic [PW-1:0] out_pred;
  logic [RW-1:0] out_resid;

  typedef struct {
    logic [3:0]    mode;
    logic [19:0]   score;
    logic [PW-1:0] pred;
    logic [RW-1:0] resid;
  } res_t;

  res_t exp_q[$];
  res_t exp_head;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  bit   rnd_ready = 1'b0;

  logic [3:0]    blk_mode[10];
  logic [PW-1:0] blk_pred[10];
  logic [PW-1:0] blk_src;
  int            blk_n;

  intra4_mode_select dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_last  (in_last),
    .in_mode  (in_mode),
    .in_src   (in_src),
    .in_pred  (in_pred),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_mode (out_mode),
    .out_score(out_score),
    .out_pred (out_pred),
    .out_resid(out_resid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: score every mode of the block, keep the first strict minimum.
  function automatic res_t model(input logic [PW-1:0] src, input int n);
    res_t r;
    int best, sse, d;
    r.mode = '0; r.score = '0; r.pred = '0; r.resid = '0;
    best = 0;
    for (int b = 0; b < n; b++) begin
      sse = 0;
      for (int i = 0; i < 16; i++) begin
        d = int'(src[8*i +: 8]) - int'(blk_pred[b][8*i +: 8]);
        sse += d * d;
      end
      if (b == 0 || sse < best) begin
        best    = sse;
        r.mode  = blk_mode[b];
        r.score = 20'(sse);
        r.pred  = blk_pred[b];
        for (int i = 0; i < 16; i++) begin
          d = int'(src[8*i +: 8]) - int'(blk_pred[b][8*i +: 8]);
          r.resid[9*i +: 9] = 9'(d);
        end
      end
    end
    return r;
  endfunction

  // Single compare process: every cycle a result is presented it must match
  // the oldest outstanding expectation; it retires on the handshake.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        check("out_valid_unexpected", 256'(out_valid), 256'(0));
      end else begin
        exp_head = exp_q[0];
        check("cmp_mode",  256'(out_mode),  256'(exp_head.mode));
        check("cmp_score", 256'(out_score), 256'(exp_head.score));
        check("cmp_pred",  256'(out_pred),  256'(exp_head.pred));
        check("cmp_resid", 256'(out_resid), 256'(exp_head.resid));
        check("cmp_in_ready_low", 256'(in_ready), 256'(0));
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic drive_beat(input logic [3:0] m, input logic [PW-1:0] s,
                            input logic [PW-1:0] p, input logic l);
    in_valid = 1'b1;
    in_mode  = m;
    in_src   = s;
    in_pred  = p;
    in_last  = l;
  endtask

  // Waits for the beat to be taken; acc is the edge count of the accepting edge.
  task automatic wait_accept(output int acc);
    int guard;
    guard = 0;
    acc   = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      guard++;
      if (guard > 300) begin
        check("accept_timeout", 256'(in_ready), 256'(1));
        in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
    acc      = cyc;
    in_valid = 1'b0;
  endtask

  task automatic send_block(input int gap_max, output int acc_last);
    logic [PW-1:0] s;
    int acc;
    acc_last = 0;
    for (int b = 0; b < blk_n; b++) begin
      s = blk_src;
      if (b != 0) for (int i = 0; i < 16; i++) s[8*i +: 8] = 8'($urandom);
      drive_beat(blk_mode[b], s, blk_pred[b], b == blk_n - 1);
      wait_accept(acc);
      repeat ($urandom_range(0, gap_max)) begin
        @(posedge clk);
        #1;
      end
    end
    acc_last = acc;
    exp_q.push_back(model(blk_src, blk_n));
  endtask

  task automatic wait_out(output int c);
    c = 0;
    for (int g = 0; g < 50; g++) begin
      @(negedge clk);
      if (out_valid) begin
        c = cyc;
        return;
      end
    end
    check("out_valid_timeout", 256'(out_valid), 256'(1));
  endtask

  task automatic wait_idle();
    for (int g = 0; g < 500; g++) begin
      @(posedge clk);
      if (exp_q.size() == 0) break;
    end
    #1;
    check("results_drained", 256'(exp_q.size()), 256'(0));
  endtask

  logic [PW-1:0] c80, c81, c82, cff, c00, c40, c41, c10, c14;
  logic [RW-1:0] r0ff, r101, r1fc;
  res_t r;
  int   acc, c;

  initial begin
    c80 = {16{8'h80}}; c81 = {16{8'h81}}; c82 = {16{8'h82}};
    cff = {16{8'hFF}}; c00 = {16{8'h00}}; c40 = {16{8'h40}};
    c41 = {16{8'h41}}; c10 = {16{8'h10}}; c14 = {16{8'h14}};
    r0ff = {16{9'h0FF}}; r101 = {16{9'h101}}; r1fc = {16{9'h1FC}};

    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_mode = '0;
    in_src = '0; in_pred = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_in_ready",  256'(in_ready),  256'(1));
    check("reset_out_valid", 256'(out_valid), 256'(0));
    check("reset_out_mode",  256'(out_mode),  256'(0));
    check("reset_out_score", 256'(out_score), 256'(0));
    check("reset_out_pred",  256'(out_pred),  256'(0));
    check("reset_out_resid", 256'(out_resid), 256'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    // Perfect single-beat match, with latency.
    blk_src = c80; blk_n = 1; blk_mode[0] = MODE_RD; blk_pred[0] = c80;
    r = model(blk_src, blk_n);
    check("model_zero_score", 256'(r.score), 256'(0));
    send_block(0, acc);
    wait_out(c);
    check("latency_edges", 256'(c - acc), 256'(3));
    check("t1_mode",  256'(out_mode),  256'(MODE_RD));
    check("t1_score", 256'(out_score), 256'(0));
    check("t1_resid", 256'(out_resid), 256'(0));
    wait_idle();

    // Tie between TM and VE: the earlier one wins.
    blk_src = c80; blk_n = 3;
    blk_mode[0] = MODE_DC; blk_pred[0] = c82;
    blk_mode[1] = MODE_TM; blk_pred[1] = c81;
    blk_mode[2] = MODE_VE; blk_pred[2] = c81;
    r = model(blk_src, blk_n);
    check("model_tie_mode",  256'(r.mode),  256'(MODE_TM));
    check("model_tie_score", 256'(r.score), 256'(16));
    send_block(0, acc);
    wait_out(c);
    check("t2_mode",  256'(out_mode),  256'(MODE_TM));
    check("t2_score", 256'(out_score), 256'(16));
    wait_idle();

    // Largest positive and negative residuals.
    blk_src = cff; blk_n = 1; blk_mode[0] = MODE_VR; blk_pred[0] = c00;
    r = model(blk_src, blk_n);
    check("model_max_resid", 256'(r.resid), 256'(r0ff));
    send_block(0, acc);
    wait_out(c);
    check("t3_score", 256'(out_score), 256'(20'hFE010));
    check("t3_resid", 256'(out_resid), 256'(r0ff));
    wait_idle();

    blk_src = c00; blk_n = 1; blk_mode[0] = MODE_LD; blk_pred[0] = cff;
    send_block(0, acc);
    wait_out(c);
    check("t4_score", 256'(out_score), 256'(20'hFE010));
    check("t4_resid", 256'(out_resid), 256'(r101));
    wait_idle();

    // Backpressure: result holds, next block's first beat waits.
    out_ready = 1'b0;
    blk_src = c40; blk_n = 1; blk_mode[0] = MODE_HE; blk_pred[0] = c41;
    send_block(0, acc);
    wait_out(c);
    @(posedge clk); #1;
    drive_beat(MODE_HU, c10, c14, 1'b1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_in_ready",  256'(in_ready),  256'(0));
      check("bp_out_valid", 256'(out_valid), 256'(1));
      check("bp_score",     256'(out_score), 256'(16));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_accept(acc);
    blk_src = c10; blk_n = 1; blk_mode[0] = MODE_HU; blk_pred[0] = c14;
    exp_q.push_back(model(blk_src, blk_n));
    wait_out(c);
    check("bp2_mode",  256'(out_mode),  256'(MODE_HU));
    check("bp2_score", 256'(out_score), 256'(256));
    check("bp2_resid", 256'(out_resid), 256'(r1fc));
    wait_idle();

    // Reset mid-block: four perfect-match beats are in flight and must vanish.
    for (int i = 0; i < 16; i++) blk_src[8*i +: 8] = 8'($urandom);
    for (int b = 0; b < 4; b++) begin
      drive_beat(MODE_DC, blk_src, blk_src, 1'b0);
      wait_accept(acc);
    end
    #2 rst = 1'b1;
    #1;
    check("rst_mid_out_valid", 256'(out_valid), 256'(0));
    check("rst_mid_in_ready",  256'(in_ready),  256'(1));
    check("rst_mid_score",     256'(out_score), 256'(0));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    blk_n = 1; blk_mode[0] = MODE_VL; blk_pred[0] = ~blk_src;
    send_block(0, acc);
    wait_out(c);
    check("rst_mid_next_mode", 256'(out_mode), 256'(MODE_VL));
    wait_idle();

    // Reset while holding a result.
    out_ready = 1'b0;
    blk_src = c80; blk_n = 1; blk_mode[0] = MODE_HD; blk_pred[0] = c82;
    send_block(0, acc);
    wait_out(c);
    #2 rst = 1'b1;
    #1;
    exp_q.delete();
    check("rst_hold_out_valid", 256'(out_valid), 256'(0));
    check("rst_hold_in_ready",  256'(in_ready),  256'(1));
    check("rst_hold_pred",      256'(out_pred),  256'(0));
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;

    // Randomized blocks with gaps and random backpressure.
    rnd_ready = 1'b1;
    for (int t = 0; t < 40; t++) begin
      blk_n = $urandom_range(1, 10);
      for (int i = 0; i < 16; i++) blk_src[8*i +: 8] = 8'($urandom);
      for (int b = 0; b < blk_n; b++) begin
        blk_mode[b] = 4'($urandom_range(0, 9));
        case ($urandom_range(0, 2))
          0: for (int i = 0; i < 16; i++) blk_pred[b][8*i +: 8] = 8'($urandom);
          1: for (int i = 0; i < 16; i++)
               blk_pred[b][8*i +: 8] = blk_src[8*i +: 8] ^ 8'($urandom_range(0, 7));
          default: blk_pred[b] = (b > 0) ? blk_pred[b-1] : blk_src ^ {16{8'h03}};
        endcase
      end
      send_block(2, acc);
    end
    wait_idle();
    rnd_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
